// File: rtl/udma_uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART RX uDMA controller.
// Byte lanes are packed little-endian into a single 32-bit word.
package udma_uart_rx_ctrl_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);
  localparam int unsigned IDLE_W     = 16;

  localparam logic [LANE_W-1:0] LANE_FIRST = '0;
  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Insert one byte into the given lane of a partially packed word.
  function automatic logic [WORD_W-1:0] pack_byte(
    input logic [WORD_W-1:0] word,
    input logic [LANE_W-1:0] lane,
    input logic [BYTE_W-1:0] data
  );
    logic [WORD_W-1:0] w_res;
    w_res = word;
    w_res[{lane, 3'b000} +: BYTE_W] = data;
    return w_res;
  endfunction

endpackage

// File: rtl/udma_uart_rx_idle_timer.sv
// Idle-line counter: saturating 16-bit count, expires at a programmable
// threshold (0 disables expiry).
module udma_uart_rx_idle_timer
  import udma_uart_rx_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [IDLE_W-1:0] i_timeout,
  output logic              o_expire_c
);

  logic [IDLE_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {IDLE_W{1'b1}})) begin
      r_cnt <= r_cnt + IDLE_W'(1);
    end
  end

  // Held level rather than a one-shot so a flush blocked by a full output slot still happens later.
  assign o_expire_c = (i_timeout != '0) && (r_cnt >= i_timeout);

endmodule

// File: rtl/udma_uart_rx_ctrl.sv
// Sequences one uDMA RX transfer: packs UART bytes into 32-bit words, hands
// them to the RX channel, counts the transfer down and flushes on idle timeout.
module udma_uart_rx_ctrl
  import udma_uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_start_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic                  cfg_stop_i,
  input  logic [IDLE_W-1:0]     cfg_timeout_i,
  input  logic [BYTE_W-1:0]     uart_data_i,
  input  logic                  uart_valid_i,
  output logic                  uart_ready_o,
  output logic [WORD_W-1:0]     dma_data_o,
  output logic [1:0]            dma_size_o,
  output logic                  dma_valid_o,
  input  logic                  dma_ready_i,
  output logic                  busy_o,
  output logic [TRANS_SIZE-1:0] bytes_left_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  state_e                r_state;
  logic [TRANS_SIZE-1:0] r_bytes_left;
  logic [LANE_W-1:0]     r_pack_cnt;
  logic [WORD_W-1:0]     r_pack;
  logic [WORD_W-1:0]     r_dma_data;
  logic [LANE_W-1:0]     r_dma_size;
  logic                  r_dma_valid;
  logic                  r_done;
  logic                  r_timeout;

  logic              w_abort;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_last;
  logic              w_commit_acc;
  logic              w_commit_to;
  logic              w_expire;
  logic              w_timer_clr;
  logic              w_timer_en;
  logic [WORD_W-1:0] w_word;

  assign w_abort      = cfg_stop_i | ~cfg_en_i;
  assign w_slot_free  = ~r_dma_valid | dma_ready_i;
  assign uart_ready_o = (r_state == ST_RUN) && (r_bytes_left != '0) && w_slot_free && !w_abort;
  assign w_accept     = uart_ready_o & uart_valid_i;
  assign w_last       = (r_bytes_left == TRANS_SIZE'(1));
  assign w_commit_acc = w_accept && ((r_pack_cnt == LANE_LAST) || w_last);
  assign w_commit_to  = (r_state == ST_RUN) && !w_abort && !w_accept && w_expire &&
                        w_slot_free && (r_pack_cnt != LANE_FIRST);
  assign w_word       = pack_byte(r_pack, r_pack_cnt, uart_data_i);
  assign w_timer_clr  = (r_state != ST_RUN) || w_abort || w_accept || w_commit_to;
  assign w_timer_en   = (r_pack_cnt != LANE_FIRST);

  udma_uart_rx_idle_timer u_idle_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_clr      (w_timer_clr),
    .i_en       (w_timer_en),
    .i_timeout  (cfg_timeout_i),
    .o_expire_c (w_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_bytes_left <= '0;
      r_pack_cnt   <= '0;
      r_pack       <= '0;
      r_dma_data   <= '0;
      r_dma_size   <= '0;
      r_dma_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (w_abort) begin
        r_state      <= ST_IDLE;
        r_bytes_left <= '0;
        r_pack_cnt   <= '0;
        r_pack       <= '0;
        r_dma_data   <= '0;
        r_dma_size   <= '0;
        r_dma_valid  <= 1'b0;
      end else begin
        if (r_dma_valid && dma_ready_i) begin
          r_dma_valid <= 1'b0;
        end
        case (r_state)
          ST_IDLE: begin
            if (cfg_start_i) begin
              r_bytes_left <= cfg_size_i;
              r_state      <= (cfg_size_i == '0) ? ST_DRAIN : ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_accept) begin
              r_bytes_left <= r_bytes_left - TRANS_SIZE'(1);
              if (w_commit_acc) begin
                r_dma_data  <= w_word;
                r_dma_size  <= r_pack_cnt;
                r_dma_valid <= 1'b1;
                r_pack      <= '0;
                r_pack_cnt  <= '0;
                if (w_last) begin
                  r_state <= ST_DRAIN;
                end
              end else begin
                r_pack     <= w_word;
                r_pack_cnt <= r_pack_cnt + LANE_W'(1);
              end
            end else if (w_commit_to) begin
              // Partial flush leaves the byte count alone; the transfer keeps running.
              r_dma_data  <= r_pack;
              r_dma_size  <= r_pack_cnt - LANE_W'(1);
              r_dma_valid <= 1'b1;
              r_pack      <= '0;
              r_pack_cnt  <= '0;
              r_timeout   <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (w_slot_free) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dma_data_o   = r_dma_data;
  assign dma_size_o   = r_dma_size;
  assign dma_valid_o  = r_dma_valid;
  assign busy_o       = (r_state != ST_IDLE);
  assign bytes_left_o = r_bytes_left;
  assign done_o       = r_done;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_udma_uart_rx_ctrl.sv
// Directed bench for udma_uart_rx_ctrl: packing, back-pressure, timeout flush,
// abort and zero-length transfers, checked against hand-computed words.
module tb_udma_uart_rx_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic        cfg_start_i;
  logic [15:0] cfg_size_i;
  logic        cfg_stop_i;
  logic [15:0] cfg_timeout_i;
  logic [7:0]  uart_data_i;
  logic        uart_valid_i;
  logic        uart_ready_o;
  logic [31:0] dma_data_o;
  logic [1:0]  dma_size_o;
  logic        dma_valid_o;
  logic        dma_ready_i;
  logic        busy_o;
  logic [15:0] bytes_left_o;
  logic        done_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_to   = 0;
  logic [31:0] q_data[$];
  logic [1:0]  q_size[$];

  udma_uart_rx_ctrl #(.TRANS_SIZE(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_start_i(cfg_start_i),
    .cfg_size_i(cfg_size_i), .cfg_stop_i(cfg_stop_i), .cfg_timeout_i(cfg_timeout_i),
    .uart_data_i(uart_data_i), .uart_valid_i(uart_valid_i), .uart_ready_o(uart_ready_o),
    .dma_data_o(dma_data_o), .dma_size_o(dma_size_o), .dma_valid_o(dma_valid_o),
    .dma_ready_i(dma_ready_i), .busy_o(busy_o), .bytes_left_o(bytes_left_o),
    .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Word sink and pulse counters.
  always @(posedge clk_i) begin
    if (dma_valid_o && dma_ready_i) begin
      q_data.push_back(dma_data_o);
      q_size.push_back(dma_size_o);
    end
    if (done_o) n_done++;
    if (timeout_o) n_to++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic start_xfer(input logic [15:0] size);
    cfg_size_i  = size;
    cfg_start_i = 1'b1;
    @(negedge clk_i);
    cfg_start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop_i = 1'b1;
    @(negedge clk_i);
    cfg_stop_i = 1'b0;
  endtask

  // Present one byte until accepted (bounded); called and returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input int max_wait, output bit ok);
    ok = 1'b0;
    uart_data_i  = b;
    uart_valid_i = 1'b1;
    for (int i = 0; i < max_wait && !ok; i++) begin
      #1;
      if (uart_ready_o) ok = 1'b1;
      @(negedge clk_i);
    end
    uart_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int max_wait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk_i);
      if (n_done != start_cnt) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_start_i = 1'b0; cfg_size_i = '0; cfg_stop_i = 1'b0;
    cfg_timeout_i = '0; uart_data_i = '0; uart_valid_i = 1'b0; dma_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    cfg_en_i = 1'b1;
    @(negedge clk_i);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (dma_valid_o !== 1'b0) begin bad++; $display("FAIL reset_dma_valid got=%b exp=0", dma_valid_o); end
    total++; if (dma_data_o !== 32'h0) begin bad++; $display("FAIL reset_dma_data got=%h exp=0", dma_data_o); end
    total++; if (bytes_left_o !== 16'h0) begin bad++; $display("FAIL reset_bytes_left got=%0d exp=0", bytes_left_o); end
    total++; if ({done_o, timeout_o, uart_ready_o} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=000", {done_o, timeout_o, uart_ready_o});
    end
  endtask

  task automatic test_word4();
    bit ok;
    int d0;
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    q_data.delete(); q_size.delete();
    d0 = n_done;
    start_xfer(16'd4);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL word4_busy got=%b exp=1", busy_o); end
    total++; if (bytes_left_o !== 16'd4) begin bad++; $display("FAIL word4_left got=%0d exp=4", bytes_left_o); end
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL word4_accept byte=%0d got=stalled exp=accepted", i); end
    end
    wait_done(d0, 20, ok);
    repeat (3) @(negedge clk_i);
    total++; if (!ok || n_done - d0 != 1) begin bad++; $display("FAIL word4_done got=%0d exp=1", n_done - d0); end
    total++; if (q_data.size() != 1) begin bad++; $display("FAIL word4_count got=%0d exp=1", q_data.size()); end
    else begin
      total++; if (q_data[0] !== 32'h44332211) begin bad++; $display("FAIL word4_data got=%h exp=44332211", q_data[0]); end
      total++; if (q_size[0] !== 2'd3) begin bad++; $display("FAIL word4_size got=%0d exp=3", q_size[0]); end
    end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL word4_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_word6();
    bit ok;
    int d0;
    q_data.delete(); q_size.delete();
    d0 = n_done;
    start_xfer(16'd6);
    total++; if (bytes_left_o !== 16'd6) begin bad++; $display("FAIL word6_left_start got=%0d exp=6", bytes_left_o); end
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL word6_accept byte=%0d got=stalled exp=accepted", i); end
      if (i == 3) begin
        total++; if (bytes_left_o !== 16'd3) begin bad++; $display("FAIL word6_left_mid got=%0d exp=3", bytes_left_o); end
      end
    end
    wait_done(d0, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL word6_done got=none exp=pulse"); end
    total++; if (bytes_left_o !== 16'd0) begin bad++; $display("FAIL word6_left_end got=%0d exp=0", bytes_left_o); end
    total++; if (q_data.size() != 2) begin bad++; $display("FAIL word6_count got=%0d exp=2", q_data.size()); end
    else begin
      total++; if (q_data[0] !== 32'h04030201 || q_size[0] !== 2'd3) begin
        bad++; $display("FAIL word6_w0 got=%h/%0d exp=04030201/3", q_data[0], q_size[0]);
      end
      total++; if (q_data[1] !== 32'h00000605 || q_size[1] !== 2'd1) begin
        bad++; $display("FAIL word6_w1 got=%h/%0d exp=00000605/1", q_data[1], q_size[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int d0;
    int stall_bad;
    logic [7:0] b;
    q_data.delete(); q_size.delete();
    d0 = n_done;
    dma_ready_i = 1'b0;
    start_xfer(16'd8);
    for (int i = 0; i < 4; i++) begin
      b = 8'hA0 + 8'(i);
      send_byte(b, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_accept byte=%0d got=stalled exp=accepted", i); end
    end
    stall_bad = 0;
    uart_data_i = 8'hA4; uart_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (uart_ready_o !== 1'b0 || dma_valid_o !== 1'b1) stall_bad++;
      @(negedge clk_i);
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall got=%0d_bad_cycles exp=0", stall_bad); end
    dma_ready_i = 1'b1;
    for (int i = 4; i < 8; i++) begin
      b = 8'hA0 + 8'(i);
      send_byte(b, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_accept byte=%0d got=stalled exp=accepted", i); end
    end
    wait_done(d0, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done got=none exp=pulse"); end
    total++; if (q_data.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", q_data.size()); end
    else begin
      total++; if (q_data[0] !== 32'hA3A2A1A0 || q_data[1] !== 32'hA7A6A5A4) begin
        bad++; $display("FAIL bp_data got=%h,%h exp=a3a2a1a0,a7a6a5a4", q_data[0], q_data[1]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    int idle;
    q_data.delete(); q_size.delete();
    t0 = n_to;
    cfg_timeout_i = 16'd10;
    start_xfer(16'd8);
    send_byte(8'hAA, 10, ok);
    send_byte(8'hBB, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_accept got=stalled exp=accepted"); end
    idle = -1;
    for (int k = 0; k < 20 && idle < 0; k++) begin
      #1;
      if (dma_valid_o) begin
        idle = k;
        total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout_o); end
      end
      @(negedge clk_i);
    end
    total++; if (idle < 10 || idle > 11) begin bad++; $display("FAIL to_latency got=%0d exp=10..11", idle); end
    @(negedge clk_i);
    total++; if (n_to - t0 != 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", n_to - t0); end
    total++; if (q_data.size() != 1) begin bad++; $display("FAIL to_count got=%0d exp=1", q_data.size()); end
    else begin
      total++; if (q_data[0] !== 32'h0000BBAA || q_size[0] !== 2'd1) begin
        bad++; $display("FAIL to_word got=%h/%0d exp=0000bbaa/1", q_data[0], q_size[0]);
      end
    end
    total++; if (busy_o !== 1'b1 || bytes_left_o !== 16'd6) begin
      bad++; $display("FAIL to_state got=busy%b/left%0d exp=busy1/left6", busy_o, bytes_left_o);
    end
    pulse_stop();
    cfg_timeout_i = '0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL to_stop got=%b exp=0", busy_o); end
  endtask

  task automatic test_stop();
    bit ok;
    int d0;
    q_data.delete(); q_size.delete();
    d0 = n_done;
    start_xfer(16'd8);
    send_byte(8'h01, 10, ok);
    send_byte(8'h02, 10, ok);
    pulse_stop();
    total++; if (busy_o !== 1'b0 || dma_valid_o !== 1'b0) begin
      bad++; $display("FAIL stop_mid got=busy%b/valid%b exp=busy0/valid0", busy_o, dma_valid_o);
    end
    dma_ready_i = 1'b0;
    start_xfer(16'd8);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 10, ok);
    total++; if (dma_valid_o !== 1'b1) begin bad++; $display("FAIL stop_pending got=%b exp=1", dma_valid_o); end
    pulse_stop();
    total++; if (dma_valid_o !== 1'b0) begin bad++; $display("FAIL stop_discard got=%b exp=0", dma_valid_o); end
    dma_ready_i = 1'b1;
    repeat (5) @(negedge clk_i);
    total++; if (n_done != d0 || q_data.size() != 0) begin
      bad++; $display("FAIL stop_side got=done%0d/words%0d exp=done0/words0", n_done - d0, q_data.size());
    end
    start_xfer(16'd4);
    send_byte(8'h5A, 10, ok); send_byte(8'h6B, 10, ok);
    send_byte(8'h7C, 10, ok); send_byte(8'h8D, 10, ok);
    wait_done(d0, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL stop_restart_done got=none exp=pulse"); end
    total++; if (q_data.size() != 1) begin bad++; $display("FAIL stop_restart_count got=%0d exp=1", q_data.size()); end
    else begin
      total++; if (q_data[0] !== 32'h8D7C6B5A) begin bad++; $display("FAIL stop_restart_word got=%h exp=8d7c6b5a", q_data[0]); end
    end
  endtask

  task automatic test_size0_and_busy_start();
    bit ok;
    int d0;
    q_data.delete(); q_size.delete();
    repeat (2) @(negedge clk_i);
    d0 = n_done;
    start_xfer(16'd0);
    total++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL size0_first got=busy%b/done%b exp=busy1/done0", busy_o, done_o);
    end
    @(negedge clk_i);
    total++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      bad++; $display("FAIL size0_second got=busy%b/done%b exp=busy0/done1", busy_o, done_o);
    end
    @(negedge clk_i);
    total++; if (done_o !== 1'b0 || n_done - d0 != 1 || q_data.size() != 0) begin
      bad++; $display("FAIL size0_after got=done%b/pulses%0d/words%0d exp=0/1/0", done_o, n_done - d0, q_data.size());
    end
    d0 = n_done;
    start_xfer(16'd4);
    send_byte(8'h10, 10, ok);
    start_xfer(16'd2);
    total++; if (bytes_left_o !== 16'd3) begin bad++; $display("FAIL busy_start got=%0d exp=3", bytes_left_o); end
    send_byte(8'h20, 10, ok); send_byte(8'h30, 10, ok); send_byte(8'h40, 10, ok);
    wait_done(d0, 20, ok);
    total++; if (!ok || q_data.size() != 1) begin bad++; $display("FAIL busy_start_words got=%0d exp=1", q_data.size()); end
    else begin
      total++; if (q_data[0] !== 32'h40302010) begin bad++; $display("FAIL busy_start_word got=%h exp=40302010", q_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_word4();
    test_word6();
    test_backpressure();
    test_timeout();
    test_stop();
    test_size0_and_busy_start();
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
